fifo_rd_stream_adapter: RTL
===========================

Name: fifo_rd_stream_adapter

Overview:
- Sits directly downstream of generic_sync_fifo and drives its read port (ren/rdata/empty).
- Converts the FIFO's 1-cycle-latency read interface into a valid/ready stream with full throughput and no combinational m_ready->fifo_ren path.
- Adds packet framing: m_last marks every PKT_LEN-th beat, and a wrapping packet counter is provided.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- PKT_LEN, 4, beats per packet; legal range 1..256.
- PKT_CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_ren  output  1  read strobe to the FIFO.
- fifo_rdata  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_ren.
- fifo_empty  input  1  FIFO empty flag.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  last beat of a packet.
- pkt_cnt  output  PKT_CNT_WIDTH  completed packets; wraps.

Behaviour:
- Reset (async assert, sync release):
  - fifo_ren=0, m_valid=0, m_last=0, m_data=0, pkt_cnt=0.
  - Internal state cleared: occupancy occ=0, pending flag pend=0, beat_cnt=0.
- Read interface:
  - FIFO read latency is fixed at 1: fifo_ren high in cycle N gives fifo_rdata valid in cycle N+1, where it is written into the skid buffer.
  - pend is a register: set in the cycle after fifo_ren=1, clear otherwise.
- Skid buffer:
  - Exactly 3 entries, ring-organised; occ ranges 0..3.
  - Write on pend. Pop on m_valid && m_ready.
  - Simultaneous write and pop: occ unchanged; write pointer and read pointer both advance.
- Read issue rule (registered terms only):
  - fifo_ren = !fifo_empty && (occ + pend <= 2).
  - Guarantees no overflow without depending on m_ready.
  - Sustains 1 beat/cycle when the FIFO stays non-empty and m_ready=1.
  - fifo_ren never asserts while fifo_empty=1.
- Stream side:
  - m_valid = (occ != 0).
  - m_data = entry at read pointer (mux of registered storage). It stays stable while m_valid && !m_ready.
  - m_valid never deasserts without a handshake.
- First-beat latency from an empty adapter:
  - fifo_empty falls in cycle N, so fifo_ren=1 in N.
  - Write occurs at the end of N+1; m_valid=1 in N+2.
- Framing:
  - beat_cnt (width clog2(PKT_LEN), minimum 1) increments on each handshake and wraps to 0 after PKT_LEN-1.
  - m_last = m_valid && (beat_cnt == PKT_LEN-1).
  - The handshake with m_last=1 increments pkt_cnt, which wraps at 2^PKT_CNT_WIDTH.
  - PKT_LEN=1: m_last = m_valid on every beat.
- Boundaries:
  - Full buffer (occ=3, or occ=2 with pend=1): fifo_ren=0 regardless of m_ready.
  - FIFO empties mid-packet: m_valid drops once the buffer drains; beat_cnt holds, and framing resumes when data returns.
  - Reset mid-operation: buffered and in-flight data are discarded, and beat_cnt restarts at 0. A partial packet is not counted.
  - m_ready high with m_valid=0: no effect.

Decomposition:
- Package fifo_stream_pkg:
  - SKID_DEPTH=3.
  - Default DATA_WIDTH=8 and PKT_LEN=4 constants.
  - Occupancy width constant.
- Sub-module stream_skid_buf:
  - 3-entry ring with wr_en/wr_data, rd_en, head data, occ output.
  - Async active-high reset.
- The top level holds the issue logic, the pend register and the framing counters.

Test Plan:
- Reset release with fifo_empty=1, m_ready=1 for 10 cycles -> fifo_ren=0 and m_valid=0 throughout, pkt_cnt=0.
- FIFO preloaded with 10,11,12,13, m_ready=1 -> fifo_ren high from cycle N, first m_valid in N+2. Data 10,11,12,13 appears on consecutive cycles, m_last only with 13, pkt_cnt 0->1.
- Same 4 words with m_ready=0 -> fifo_ren stops after 3 reads, occ=3, m_data holds 10. Raising m_ready drains 10..13 back-to-back.
- m_ready toggling 1,0,1,0 over 8 words (10..17) -> order preserved, no loss or duplication. m_last on 13 and 17, pkt_cnt=2.
- 6 words (20..25) then FIFO empty -> m_last on 23. After 24,25, m_valid drops with beat_cnt=2. Pushing 26,27 gives m_last on 27.
- rst pulsed while occ=2, pend=1 -> all outputs 0 immediately (async). After release, the next FIFO word is treated as beat 0 of a packet.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared constants, types and helpers for the FIFO read-to-stream adapter.
package fifo_stream_pkg;

  localparam int SKID_DEPTH     = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PKT_LEN    = 4;

  // Occupancy must represent 0..SKID_DEPTH; pointers index 0..SKID_DEPTH-1.
  localparam int OCC_WIDTH = $clog2(SKID_DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(SKID_DEPTH);

  typedef logic [OCC_WIDTH-1:0] occ_t;
  typedef logic [PTR_WIDTH-1:0] ptr_t;

  // Ring pointer advance; depth is not a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? '0 : ptr_t'(p + ptr_t'(1));
  endfunction

  // Beat counter width: enough for 0..pkt_len-1, never narrower than 1 bit.
  function automatic int beat_width(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry ring buffer that absorbs FIFO read data already in flight,
// so that the read strobe never has to depend on downstream ready.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;

  // Entry storage: written at the write pointer whenever returning data lands.
  // NOTE: storage is reset (unusual for a memory) because head drives m_data
  // directly and the stream data must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; a write and a pop together leave occ alone.
  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ_t'(occ + occ_t'(1));
        2'b01:   occ <= occ_t'(occ - occ_t'(1));
        default: occ <= occ;
      endcase
    end
  end

  // Head of the ring, a plain mux of registered storage.
  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream with
// packet framing (m_last every PKT_LEN beats) and a completed-packet counter.
module fifo_rd_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int PKT_LEN       = DEF_PKT_LEN,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     fifo_ren,
  input  logic [DATA_WIDTH-1:0]    fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

  localparam int                    BEAT_WIDTH = beat_width(PKT_LEN);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(PKT_LEN - 1);

  logic                  pend;
  occ_t                  occ;
  logic                  pop;
  logic [OCC_WIDTH:0]    committed;
  logic [BEAT_WIDTH-1:0] beat_cnt;

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pend),
    .wr_data (fifo_rdata),
    .rd_en   (pop),
    .head    (m_data),
    .occ     (occ)
  );

  // Read issue: only registered occupancy and the in-flight flag decide, so
  // there is no m_ready -> fifo_ren path; the slot count covers the worst case.
  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    committed = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, pend};
    fifo_ren  = !rst && !fifo_empty && (committed <= (OCC_WIDTH + 1)'(SKID_DEPTH - 1));
  end

  // Stream handshake and framing flags.
  always_comb begin
    m_valid = (occ != '0);
    pop     = m_valid && m_ready;
    m_last  = m_valid && (beat_cnt == LAST_BEAT);
  end

  // In-flight flag: read data arrives exactly one cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= fifo_ren;
  end

  // Beat position within the current packet; holds while the stream idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : BEAT_WIDTH'(beat_cnt + 1'b1);
    end
  end

  // Completed-packet counter, bumped by the handshake carrying m_last; wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pop && m_last) begin
      pkt_cnt <= PKT_CNT_WIDTH'(pkt_cnt + 1'b1);
    end
  end

endmodule
